pc_update_ras: RTL and testbench
================================

// Module: pc_update_ras
// PURPOSE
//   Sequential PC-update stage for the Y86-64 SEQ core.
//   Registers the next PC from icode/cnd/valC/valM/valP, and supports stall (en).
//   Runs a sticky RUN/HALT/ERR status FSM.
//   Keeps a circular return-address stack (RAS) that predicts ret targets and flags mispredicts.
//   Sits after write-back; pc feeds the fetch stage next cycle.
// PARAMETERS
//   ADDR_W     64   width of pc, valC, valM, valP and RAS entries
//   RAS_DEPTH  8    RAS entries; power of two, >=2
//   RESET_PC   0    pc value loaded on reset
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   en             in   1       1 = retire current instruction; 0 = stall (hold all state)
//   icode          in   4       instruction code of retiring instruction
//   cnd            in   1       condition result for jXX
//   valC           in   ADDR_W  constant / jump or call target
//   valM           in   ADDR_W  memory read value (ret target)
//   valP           in   ADDR_W  sequential next PC
//   pc             out  ADDR_W  registered program counter
//   stat           out  2       00 AOK, 01 HLT, 10 INS (invalid icode)
//   ras_top        out  ADDR_W  predicted return address (top entry); 0 when empty
//   ras_empty      out  1       1 when RAS holds no entries
//   ras_mispredict out  1       one-cycle pulse: ret target valM != predicted top
//   ras_overflow   out  1       one-cycle pulse: call pushed into a full RAS
//   ras_underflow  out  1       one-cycle pulse: ret executed with RAS empty
// BEHAVIOUR
//   Reset (rst_n=0, async): pc=RESET_PC, state=RUN, stat=00, RAS count=0, pointers=0.
//     All pulses = 0 and ras_top = 0.
//   Update happens on a posedge only when en=1 and state=RUN; otherwise all regs hold.
//     Pulses deassert on any edge without an event.
//   Next PC (registered, 1-cycle latency, visible after the edge):
//     icode 0 (halt): pc holds; state->HALT; stat=01.
//     icode 7 (jXX):  pc<=cnd ? valC : valP.
//     icode 8 (call): pc<=valC; push valP.
//     icode 9 (ret):  pc<=valM; pop if non-empty.
//     icode 1-6, A, B: pc<=valP.
//     icode C-F:      pc holds; state->ERR; stat=10.
//   FSM: RUN->HALT on halt; RUN->ERR on invalid icode.
//     HALT and ERR are sticky until rst_n; en is ignored there.
//   RAS: circular buffer with top pointer (log2 RAS_DEPTH bits, wraps modulo depth) and count (0..RAS_DEPTH).
//     Push: top<=top+1 (wrap), write entry, count++.
//       If count==RAS_DEPTH: overwrite the oldest entry, count stays at RAS_DEPTH, ras_overflow pulses.
//     Pop: compare entry[top] with valM.
//       Mismatch -> ras_mispredict pulses.
//       Then top<=top-1 (wrap) and count--.
//     Pop with count==0: no pointer change, ras_underflow pulses, pc still <=valM, no mispredict.
//   ras_top is the registered entry at the current top; ras_empty = (count==0).
//   Arithmetic: no PC arithmetic inside the block; all widths ADDR_W; pointer arithmetic wraps.
//   Reset mid-stall or mid-HALT: async reset overrides and returns everything to reset values.
// TESTING
//   1. Reset, en=1: jXX cnd=1 valC=0x40 -> pc=0x40; jXX cnd=0 valP=0x49 -> pc=0x49.
//   2. call valC=0x100 valP=0x2A, then ret valM=0x2A:
//      after call pc=0x100, ras_top=0x2A; after ret pc=0x2A, ras_empty=1, no mispredict.
//   3. call valP=0x2A, then ret valM=0x33 -> pc=0x33, ras_mispredict=1 for exactly one cycle.
//   4. RAS_DEPTH+1 calls with valP=1..9 -> ras_overflow pulses on the 9th call, ras_top=9.
//      Then 8 rets with matching valM pop 9..2 with no mispredict.
//      A 9th ret gives ras_underflow=1.
//   5. en=0 with a call and icode 0 present -> pc, RAS and stat unchanged.
//      Then en=1 halt -> stat=01, pc holds.
//      Further jXX with en=1 is ignored; rst_n low -> pc=RESET_PC, stat=00.
//   6. icode 0xE in RUN -> stat=10, pc unchanged, later calls do not push.

Source files
------------

// File: rtl/pc_update_ras.sv
// PC-update stage for the Y86-64 SEQ core: registered next PC, sticky RUN/HALT/ERR
// status and a circular return-address stack that predicts ret targets.
module pc_update_ras #(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        icode,
    input  logic              cnd,
    input  logic [ADDR_W-1:0] valC,
    input  logic [ADDR_W-1:0] valM,
    input  logic [ADDR_W-1:0] valP,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        stat,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_mispredict,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HALT = 2'b01,
        S_ERR  = 2'b10
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pc_d;
    logic                do_push;
    logic                do_pop;
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W-1:0]    top_inc;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   entries [RAS_DEPTH];

    assign top_inc   = top_ptr + 1'b1;
    assign ras_empty = (count == '0);
    assign ras_top   = ras_empty ? '0 : entries[top_ptr];
    assign stat      = state_q;

    // Decode of the retiring instruction; nothing moves unless retiring in RUN
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (en && state_q == S_RUN) begin
            case (icode)
                4'h0: state_d = S_HALT;
                4'h7: pc_d = cnd ? valC : valP;
                4'h8: begin
                    pc_d    = valC;
                    do_push = 1'b1;
                end
                4'h9: begin
                    pc_d   = valM;
                    do_pop = 1'b1;
                end
                4'hC, 4'hD, 4'hE, 4'hF: state_d = S_ERR;
                default: pc_d = valP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_RUN;
            pc             <= RESET_PC;
            top_ptr        <= '0;
            count          <= '0;
            ras_mispredict <= 1'b0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc             <= pc_d;
            ras_mispredict <= 1'b0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
            // A push into a full stack lands on the oldest slot, so count saturates
            if (do_push) begin
                top_ptr <= top_inc;
                if (count == FULL) begin
                    ras_overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
            if (do_pop) begin
                if (count == '0) begin
                    ras_underflow <= 1'b1;
                end else begin
                    ras_mispredict <= (entries[top_ptr] != valM);
                    top_ptr        <= top_ptr - 1'b1;
                    count          <= count - 1'b1;
                end
            end
        end
    end

    // Entry storage needs no reset: ras_top masks it while the stack is empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[top_inc] <= valP;
        end
    end

endmodule

// File: tb/tb_pc_update_ras.sv
// Directed bench for pc_update_ras with a queue-based reference model checked every cycle.
module tb_pc_update_ras;

    localparam int ADDR_W = 64;
    localparam int DEPTH  = 8;
    localparam logic [ADDR_W-1:0] RST_PC = 64'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [3:0]        icode = 4'h1;
    logic              cnd = 1'b0;
    logic [ADDR_W-1:0] valC = '0;
    logic [ADDR_W-1:0] valM = '0;
    logic [ADDR_W-1:0] valP = '0;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        stat;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_mispredict;
    logic              ras_overflow;
    logic              ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    pc_update_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .icode(icode), .cnd(cnd),
        .valC(valC), .valM(valM), .valP(valP), .pc(pc), .stat(stat),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_mispredict(ras_mispredict),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a bounded queue for the stack, plain variables for pc/status
    logic [ADDR_W-1:0] m_pc;
    logic [1:0]        m_stat;
    logic              m_mis, m_ovf, m_unf;
    logic [ADDR_W-1:0] m_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = RST_PC; m_stat = 2'd0; m_mis = 0; m_ovf = 0; m_unf = 0;
            m_q.delete();
        end else begin
            m_mis = 0; m_ovf = 0; m_unf = 0;
            if (en && m_stat == 2'd0) begin
                if (icode == 4'h0) m_stat = 2'd1;
                else if (icode >= 4'hC) m_stat = 2'd2;
                else if (icode == 4'h7) m_pc = cnd ? valC : valP;
                else if (icode == 4'h8) begin
                    m_pc = valC;
                    if (m_q.size() == DEPTH) begin
                        void'(m_q.pop_front());
                        m_ovf = 1;
                    end
                    m_q.push_back(valP);
                end else if (icode == 4'h9) begin
                    m_pc = valM;
                    if (m_q.size() == 0) m_unf = 1;
                    else begin
                        if (m_q[$] != valM) m_mis = 1;
                        void'(m_q.pop_back());
                    end
                end else m_pc = valP;
            end
        end
    end

    task automatic check(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_pc", pc, m_pc);
            check("model_stat", {62'd0, stat}, {62'd0, m_stat});
            check("model_ras_top", ras_top, (m_q.size() == 0) ? '0 : m_q[$]);
            check("model_ras_empty", {63'd0, ras_empty}, {63'd0, m_q.size() == 0});
            check("model_mispredict", {63'd0, ras_mispredict}, {63'd0, m_mis});
            check("model_overflow", {63'd0, ras_overflow}, {63'd0, m_ovf});
            check("model_underflow", {63'd0, ras_underflow}, {63'd0, m_unf});
        end
    end

    task automatic step(input logic e, input logic [3:0] ic, input logic c,
                        input logic [ADDR_W-1:0] vc, input logic [ADDR_W-1:0] vm,
                        input logic [ADDR_W-1:0] vp);
        en = e; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_pc", pc, RST_PC);
        check("reset_empty", {63'd0, ras_empty}, 64'd1);
        check("reset_top", ras_top, 64'd0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // jumps
        step(1, 4'h7, 1, 64'h40, 0, 64'h09);
        check("jxx_taken_pc", pc, 64'h40);
        step(1, 4'h7, 0, 64'h99, 0, 64'h49);
        check("jxx_not_taken_pc", pc, 64'h49);

        // call / matching ret
        step(1, 4'h8, 0, 64'h100, 0, 64'h2A);
        check("call_pc", pc, 64'h100);
        check("call_top", ras_top, 64'h2A);
        step(1, 4'h9, 0, 0, 64'h2A, 0);
        check("ret_pc", pc, 64'h2A);
        check("ret_empty", {63'd0, ras_empty}, 64'd1);
        check("ret_no_mis", {63'd0, ras_mispredict}, 64'd0);

        // mispredicting ret pulses for one cycle
        step(1, 4'h8, 0, 64'h200, 0, 64'h2A);
        step(1, 4'h9, 0, 0, 64'h33, 0);
        check("mis_pc", pc, 64'h33);
        check("mis_pulse", {63'd0, ras_mispredict}, 64'd1);
        step(1, 4'h1, 0, 0, 0, 64'h34);
        check("mis_clear", {63'd0, ras_mispredict}, 64'd0);

        // overflow, full drain, underflow
        for (int i = 1; i <= DEPTH + 1; i++) begin
            step(1, 4'h8, 0, 64'h300, 0, ADDR_W'(i));
            if (i == DEPTH) check("no_ovf_at_full", {63'd0, ras_overflow}, 64'd0);
        end
        check("ovf_pulse", {63'd0, ras_overflow}, 64'd1);
        check("ovf_top", ras_top, 64'd9);
        for (int i = 9; i >= 2; i--) begin
            step(1, 4'h9, 0, 0, ADDR_W'(i), 0);
            check("drain_no_mis", {63'd0, ras_mispredict}, 64'd0);
        end
        check("drain_empty", {63'd0, ras_empty}, 64'd1);
        step(1, 4'h9, 0, 0, 64'h77, 0);
        check("unf_pulse", {63'd0, ras_underflow}, 64'd1);
        check("unf_pc", pc, 64'h77);

        // stall, halt, sticky halt, async reset
        step(0, 4'h8, 0, 64'h500, 0, 64'h55);
        check("stall_pc", pc, 64'h77);
        check("stall_empty", {63'd0, ras_empty}, 64'd1);
        step(0, 4'h0, 0, 0, 0, 0);
        check("stall_stat", {62'd0, stat}, 64'd0);
        step(1, 4'h0, 0, 0, 0, 64'h80);
        check("halt_stat", {62'd0, stat}, 64'd1);
        check("halt_pc", pc, 64'h77);
        step(1, 4'h7, 1, 64'h600, 0, 0);
        check("halt_sticky_pc", pc, 64'h77);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, RST_PC);
        check("async_rst_stat", {62'd0, stat}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // invalid instruction
        step(1, 4'h1, 0, 0, 0, 64'h10);
        check("pre_ins_pc", pc, 64'h10);
        step(1, 4'hE, 0, 0, 0, 64'h12);
        check("ins_stat", {62'd0, stat}, 64'd2);
        check("ins_pc", pc, 64'h10);
        step(1, 4'h8, 0, 64'h700, 0, 64'h14);
        check("ins_no_push", {63'd0, ras_empty}, 64'd1);
        check("ins_pc_hold", pc, 64'h10);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
